// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: controller states, opcode and aluop
// encodings, and the datapath mux select values.
package mips_pkg;

    // 4-bit state register; encodings 13..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ORIEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JEX     = 4'd12
    } statetype_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control word produced by the controller each cycle.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/
// writeback, stalling on the memory-ready handshake.
module mc_control_fsm
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [2:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal_op
);

    statetype_t state_q, state_d;
    ctrl_t      ctrl;

    // NOTE: state is the only storage here; sequential logic uses <= so all
    // flops update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output is defaulted first so no path infers a latch.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem_op(op)) begin
                    state_d = S_MEMADR;
                end else begin
                    case (op)
                        OP_RTYPE: state_d = S_RTYPEEX;
                        OP_BEQ:   state_d = S_BEQEX;
                        OP_ADDI:  state_d = S_ADDIEX;
                        OP_ORI:   state_d = S_ORIEX;
                        OP_J:     state_d = S_JEX;
                        default:  state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_IMMWB;
            S_ORIEX:   state_d = S_IMMWB;
            S_IMMWB:   state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore decode; mem_ready gates the writes of the memory states, and the
    // whole word is cleared while reset is high so no partial write escapes.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.alusrcb = ALUSRCB_FOUR;
                    ctrl.aluop   = ALUOP_ADD;
                    ctrl.pcsrc   = PCSRC_ALU;
                    ctrl.irwrite = mem_ready;
                    ctrl.pcwrite = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alusrcb = ALUSRCB_IMMSH;
                    ctrl.aluop   = ALUOP_ADD;
                    case (op)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
                        OP_ADDI, OP_ORI, OP_J: ctrl.illegal_op = 1'b0;
                        default:               ctrl.illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR, S_ADDIEX: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = ALUSRCB_IMM;
                    ctrl.aluop   = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.iord    = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.memtoreg = 1'b1;
                    ctrl.regwrite = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_req  = 1'b1;
                    ctrl.iord     = 1'b1;
                    ctrl.memwrite = mem_ready;
                end
                S_RTYPEEX: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = ALUSRCB_RT;
                    ctrl.aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    ctrl.regdst   = 1'b1;
                    ctrl.regwrite = 1'b1;
                end
                S_BEQEX: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = ALUSRCB_RT;
                    ctrl.aluop   = ALUOP_SUB;
                    ctrl.pcsrc   = PCSRC_ALUOUT;
                    ctrl.branch  = 1'b1;
                end
                S_ORIEX: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = ALUSRCB_IMM;
                    ctrl.zeroext = 1'b1;
                    ctrl.aluop   = ALUOP_OR;
                end
                S_IMMWB: ctrl.regwrite = 1'b1;
                S_JEX: begin
                    ctrl.pcsrc   = PCSRC_JUMP;
                    ctrl.pcwrite = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign mem_req    = ctrl.mem_req;
    assign iord       = ctrl.iord;
    assign irwrite    = ctrl.irwrite;
    assign memwrite   = ctrl.memwrite;
    assign regwrite   = ctrl.regwrite;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign zeroext    = ctrl.zeroext;
    assign aluop      = ctrl.aluop;
    assign pcsrc      = ctrl.pcsrc;
    assign pcen       = ctrl.pcwrite | (ctrl.branch & zero);
    assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle expected control words
// are queued as stimulus is driven and compared mid-cycle.
module tb_mc_control_fsm;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, irwrite, memwrite, regwrite, regdst, memtoreg;
    logic       alusrca, zeroext, pcen, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string      tag;
        logic [17:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .aluop(aluop),
        .pcsrc(pcsrc), .pcen(pcen), .illegal_op(illegal_op)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Field order: mem_req iord irwrite memwrite regwrite regdst memtoreg
    // alusrca alusrcb[2] zeroext aluop[3] pcsrc[2] pcen illegal_op
    function automatic logic [17:0] pack(input logic mr, io, irw, mw, rw, rd, mtr,
                                         input logic asa, input logic [1:0] asb,
                                         input logic zx, input logic [2:0] aop,
                                         input logic [1:0] ps, input logic pe, ill);
        return {mr, io, irw, mw, rw, rd, mtr, asa, asb, zx, aop, ps, pe, ill};
    endfunction

    // Expected control word for a named state, straight from the state table.
    function automatic logic [17:0] exp_out(input string st, input logic rdy, input logic z);
        case (st)
            "FETCH":   return pack(1, 0, rdy, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 2'b00, rdy, 0);
            "DECODE":  return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 3'b000, 2'b00, 0, 0);
            "ILLEGAL": return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 3'b000, 2'b00, 0, 1);
            "MEMADR":  return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 3'b000, 2'b00, 0, 0);
            "MEMRD":   return pack(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0);
            "MEMWB":   return pack(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0);
            "MEMWR":   return pack(1, 1, 0, rdy, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0);
            "RTYPEEX": return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b010, 2'b00, 0, 0);
            "ALUWB":   return pack(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0);
            "BEQEX":   return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b001, 2'b01, z, 0);
            "ADDIEX":  return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 3'b000, 2'b00, 0, 0);
            "ORIEX":   return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 3'b011, 2'b00, 0, 0);
            "IMMWB":   return pack(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0);
            "JEX":     return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b10, 1, 0);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [17:0] observed();
        return {mem_req, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
                alusrca, alusrcb, zeroext, aluop, pcsrc, pcen, illegal_op};
    endfunction

    // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
    task automatic step(input string tag, input string st, input logic rst,
                        input logic [5:0] opc, input logic rdy, input logic z);
        sb_entry_t e;
        reset     = rst;
        op        = opc;
        mem_ready = rdy;
        zero      = z;
        e.tag = tag;
        e.exp = rst ? 18'h0 : exp_out(st, rdy, z);
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, 32'(observed()), 32'(e.exp));
            check({e.tag, "_we_onehot"},
                  32'(($countones({regwrite, memwrite, irwrite}) <= 1) &&
                      (!memwrite || (mem_req && mem_ready))), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset for two cycles, then fetch with memory ready.
        step("rst0", "", 1, OP_LW, 1, 0);
        step("rst1", "", 1, OP_LW, 1, 0);

        step("lw_fetch",  "FETCH",  0, OP_LW, 1, 0);
        step("lw_decode", "DECODE", 0, OP_LW, 1, 0);
        step("lw_memadr", "MEMADR", 0, OP_LW, 1, 0);
        step("lw_memrd",  "MEMRD",  0, OP_LW, 1, 0);
        step("lw_memwb",  "MEMWB",  0, OP_LW, 1, 0);

        // sw with three stalled MEMWR cycles.
        step("sw_fetch",  "FETCH",  0, OP_SW, 1, 0);
        step("sw_decode", "DECODE", 0, OP_SW, 1, 0);
        step("sw_memadr", "MEMADR", 0, OP_SW, 1, 0);
        for (int i = 0; i < 3; i++) step("sw_stall", "MEMWR", 0, OP_SW, 0, 0);
        step("sw_memwr",  "MEMWR",  0, OP_SW, 1, 0);

        // R-type behind a two-cycle fetch stall.
        step("rt_fstall0", "FETCH",  0, OP_RTYPE, 0, 0);
        step("rt_fstall1", "FETCH",  0, OP_RTYPE, 0, 0);
        step("rt_fetch",   "FETCH",  0, OP_RTYPE, 1, 0);
        step("rt_decode",  "DECODE", 0, OP_RTYPE, 1, 0);
        step("rt_ex",      "RTYPEEX",0, OP_RTYPE, 1, 1);
        step("rt_wb",      "ALUWB",  0, OP_RTYPE, 1, 1);

        // beq taken, then not taken; zero is also high outside BEQEX.
        step("beq1_fetch",  "FETCH",  0, OP_BEQ, 1, 0);
        step("beq1_decode", "DECODE", 0, OP_BEQ, 1, 1);
        step("beq1_ex",     "BEQEX",  0, OP_BEQ, 1, 1);
        step("beq0_fetch",  "FETCH",  0, OP_BEQ, 1, 0);
        step("beq0_decode", "DECODE", 0, OP_BEQ, 1, 0);
        step("beq0_ex",     "BEQEX",  0, OP_BEQ, 1, 0);

        step("addi_fetch",  "FETCH",  0, OP_ADDI, 1, 0);
        step("addi_decode", "DECODE", 0, OP_ADDI, 1, 0);
        step("addi_ex",     "ADDIEX", 0, OP_ADDI, 1, 1);
        step("addi_wb",     "IMMWB",  0, OP_ADDI, 1, 1);

        step("ori_fetch",  "FETCH",  0, OP_ORI, 1, 0);
        step("ori_decode", "DECODE", 0, OP_ORI, 1, 0);
        step("ori_ex",     "ORIEX",  0, OP_ORI, 1, 0);
        step("ori_wb",     "IMMWB",  0, OP_ORI, 1, 0);

        step("j_fetch",  "FETCH",  0, OP_J, 1, 0);
        step("j_decode", "DECODE", 0, OP_J, 1, 0);
        step("j_ex",     "JEX",    0, OP_J, 1, 0);

        // Unknown opcode: one-cycle illegal pulse, then straight back to FETCH.
        step("ill_fetch",  "FETCH",   0, 6'b111111, 1, 0);
        step("ill_decode", "ILLEGAL", 0, 6'b111111, 1, 0);

        // lw with one stalled MEMRD cycle.
        step("lws_fetch",  "FETCH",  0, OP_LW, 1, 0);
        step("lws_decode", "DECODE", 0, OP_LW, 1, 0);
        step("lws_memadr", "MEMADR", 0, OP_LW, 1, 0);
        step("lws_stall",  "MEMRD",  0, OP_LW, 0, 0);
        step("lws_memrd",  "MEMRD",  0, OP_LW, 1, 0);
        step("lws_memwb",  "MEMWB",  0, OP_LW, 1, 0);

        // Reset during a stalled store: memory becomes ready in the reset cycle.
        step("swr_fetch",  "FETCH",  0, OP_SW, 1, 0);
        step("swr_decode", "DECODE", 0, OP_SW, 1, 0);
        step("swr_memadr", "MEMADR", 0, OP_SW, 1, 0);
        step("swr_stall",  "MEMWR",  0, OP_SW, 0, 0);
        step("swr_reset",  "",       1, OP_SW, 1, 0);
        step("swr_resume", "FETCH",  0, OP_SW, 1, 0);
        step("swr_decode2","DECODE", 0, OP_SW, 1, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
